// File: rtl/fifo_wptr_full.sv
// ---------------------------------------------------------------------------
// fifo_wptr_full
//
// Write-domain half of an asynchronous FIFO. It holds the binary write
// pointer, which addresses the dual-port memory, and the Gray-coded copy that
// is exported to the read domain. It brings the read-domain Gray pointer in
// through a two-flop synchroniser. From these it derives the registered full
// flag, the almost-full flag, a conservative fill level and a sticky overflow
// flag.
//
// Parameters
//   ADDR_WIDTH   : memory address width; depth = 2**ADDR_WIDTH (>= 2)
//   AFULL_THRESH : fill level at or above which walmost_full asserts
//                  (1 .. 2**ADDR_WIDTH)
//
// Ports
//   wclk         in   write-domain clock
//   wrst         in   synchronous active-high reset, dominates all inputs
//   winc         in   write request from the producer
//   rptr_gray    in   Gray read pointer, asynchronous to wclk
//   wovf_clr     in   clears the sticky overflow flag (a new set wins)
//   waddr        out  memory write address, taken straight from the pointer
//   wptr_gray    out  registered Gray write pointer for the read domain
//   wfull        out  FIFO full; also gates memory writes
//   walmost_full out  fill level >= AFULL_THRESH
//   wlevel       out  write-side fill count, 0 .. 2**ADDR_WIDTH
//   woverflow    out  sticky: a write was attempted while full
// ---------------------------------------------------------------------------
module fifo_wptr_full #(
  parameter int ADDR_WIDTH   = 4,
  parameter int AFULL_THRESH = 12
) (
  input  logic                  wclk,
  input  logic                  wrst,
  input  logic                  winc,
  input  logic [ADDR_WIDTH:0]   rptr_gray,
  input  logic                  wovf_clr,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [ADDR_WIDTH:0]   wptr_gray,
  output logic                  wfull,
  output logic                  walmost_full,
  output logic [ADDR_WIDTH:0]   wlevel,
  output logic                  woverflow
);

  localparam int AW = ADDR_WIDTH;

  // Threshold resized to the level width so the compare is width-matched.
  localparam logic [AW:0] L_THRESH = (AW+1)'(AFULL_THRESH);

  // Gray -> binary: each binary bit is the XOR of all Gray bits above and
  // including it (prefix XOR starting at the MSB).
  function automatic logic [AW:0] gray2bin(input logic [AW:0] g);
    logic [AW:0] b;
    b[AW] = g[AW];
    for (int i = AW - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [AW:0] bin2gray(input logic [AW:0] b);
    return (b >> 1) ^ b;
  endfunction

  // State registers
  logic [AW:0] r_wbin;
  logic [AW:0] r_wgray;
  logic [AW:0] r_wq1;
  logic [AW:0] r_wq2;
  logic        r_wfull;
  logic        r_walmost;
  logic [AW:0] r_wlevel;
  logic        r_wovf;

  // Combinational next-state terms
  logic        w_push;
  logic [AW:0] w_bin_next;
  logic [AW:0] w_gray_next;
  logic [AW:0] w_rbin;
  logic [AW:0] w_level_next;
  logic [AW:0] w_full_pattern;
  logic        w_full_next;
  logic        w_ovf_next;

  // ---- stage: next-pointer and flag computation ----
  always_comb begin
    w_push      = winc & ~r_wfull;
    w_bin_next  = r_wbin + {{AW{1'b0}}, w_push};
    w_gray_next = bin2gray(w_bin_next);

    // The write pointer is exactly one full lap ahead of the read pointer
    // when its two Gray MSBs are inverted and the rest match.
    w_full_pattern = {~r_wq2[AW:AW-1], r_wq2[AW-2:0]};
    w_full_next    = (w_gray_next == w_full_pattern);

    // Modulo-2**(AW+1) difference. The synchronised read pointer lags, so
    // the level can only be overstated, never understated.
    w_rbin       = gray2bin(r_wq2);
    w_level_next = w_bin_next - w_rbin;

    // A new overflow event takes precedence over a clear in the same cycle.
    w_ovf_next = r_wovf;
    if (winc && r_wfull) begin
      w_ovf_next = 1'b1;
    end else if (wovf_clr) begin
      w_ovf_next = 1'b0;
    end
  end

  // ---- stage: registered pointers, synchroniser and flags ----
  always_ff @(posedge wclk) begin
    if (wrst) begin
      r_wbin    <= '0;
      r_wgray   <= '0;
      r_wq1     <= '0;
      r_wq2     <= '0;
      r_wfull   <= 1'b0;
      r_walmost <= 1'b0;
      r_wlevel  <= '0;
      r_wovf    <= 1'b0;
    end else begin
      r_wbin    <= w_bin_next;
      r_wgray   <= w_gray_next;
      // Plain two-flop chain; nothing may sit between the stages.
      r_wq1     <= rptr_gray;
      r_wq2     <= r_wq1;
      r_wfull   <= w_full_next;
      r_walmost <= (w_level_next >= L_THRESH);
      r_wlevel  <= w_level_next;
      r_wovf    <= w_ovf_next;
    end
  end

  // ---- stage: outputs ----
  // The memory writes on the same edge that advances the pointer, so the
  // address comes straight from the current binary pointer.
  assign waddr        = r_wbin[AW-1:0];
  assign wptr_gray    = r_wgray;
  assign wfull        = r_wfull;
  assign walmost_full = r_walmost;
  assign wlevel       = r_wlevel;
  assign woverflow    = r_wovf;

endmodule

// File: tb/tb_fifo_wptr_full.sv
// ---------------------------------------------------------------------------
// tb_fifo_wptr_full
//
// Scoreboard bench for fifo_wptr_full (ADDR_WIDTH = 4, AFULL_THRESH = 12).
// The stimulus process keeps an integer-count reference model: the number of
// accepted writes, and the read count as the write side sees it, which lags
// the read count driven onto rptr_gray by two edges. For each clock it pushes
// the expected post-edge outputs into a queue. A separate monitor pops the
// queue on the falling edge and compares the expected values with the DUT.
// ---------------------------------------------------------------------------
module tb_fifo_wptr_full;

  logic       wclk = 1'b0;
  logic       wrst = 1'b1;
  logic       winc = 1'b0;
  logic [4:0] rptr_gray = '0;
  logic       wovf_clr = 1'b0;
  logic [3:0] waddr;
  logic [4:0] wptr_gray;
  logic       wfull;
  logic       walmost_full;
  logic [4:0] wlevel;
  logic       woverflow;

  fifo_wptr_full #(.ADDR_WIDTH(4), .AFULL_THRESH(12)) dut (
    .wclk(wclk), .wrst(wrst), .winc(winc), .rptr_gray(rptr_gray),
    .wovf_clr(wovf_clr), .waddr(waddr), .wptr_gray(wptr_gray),
    .wfull(wfull), .walmost_full(walmost_full), .wlevel(wlevel),
    .woverflow(woverflow)
  );

  always #5 wclk = ~wclk;

  typedef struct {
    int unsigned tgt;
    logic        rst;
    logic        push;
    logic [3:0]  waddr;
    logic [4:0]  gray;
    logic        full;
    logic        afull;
    logic [4:0]  level;
    logic        ovf;
  } exp_t;

  exp_t        q[$];
  int unsigned ecount = 0;
  int          checks = 0;
  int          errors = 0;

  always @(posedge wclk) ecount <= ecount + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at edge %0d: actual=%0h required=%0h", nm, ecount, act, req);
    end
  endtask

  // ---------------- monitor ----------------
  logic [4:0] prev_gray = '0;
  always @(negedge wclk) begin
    while (q.size() > 0 && q[0].tgt <= ecount) begin
      exp_t e;
      e = q.pop_front();
      chk("waddr", 32'(waddr), 32'(e.waddr));
      chk("wptr_gray", 32'(wptr_gray), 32'(e.gray));
      chk("wfull", 32'(wfull), 32'(e.full));
      chk("walmost_full", 32'(walmost_full), 32'(e.afull));
      chk("wlevel", 32'(wlevel), 32'(e.level));
      chk("woverflow", 32'(woverflow), 32'(e.ovf));
      if (!e.rst) begin
        chk("gray_step", 32'($countones(prev_gray ^ wptr_gray)), e.push ? 32'd1 : 32'd0);
      end
      prev_gray = wptr_gray;
    end
  end

  // ---------------- reference model + stimulus ----------------
  int   m_w   = 0;   // accepted writes since reset (no wrap)
  int   rcnt  = 0;   // read count driven onto rptr_gray (no wrap)
  int   s1    = 0;   // read count driven one edge ago
  int   s2    = 0;   // read count driven two edges ago
  logic m_full = 1'b0;
  logic m_ovf  = 1'b0;

  function automatic logic [4:0] to_gray(input int n);
    logic [4:0] b;
    b = n[4:0];
    return b ^ (b >> 1);
  endfunction

  task automatic step(input logic inc, input logic clr, input logic rst_i);
    exp_t e;
    int   lvl;
    if (rst_i) rcnt = 0;
    wrst      = rst_i;
    winc      = inc;
    wovf_clr  = clr;
    rptr_gray = to_gray(rcnt);
    e.tgt = ecount + 1;
    e.rst = rst_i;
    if (rst_i) begin
      m_w = 0; s1 = 0; s2 = 0; m_full = 1'b0; m_ovf = 1'b0;
      e.push = 1'b0;
      lvl = 0;
    end else begin
      e.push = inc && !m_full;
      if (inc && m_full) m_ovf = 1'b1;
      else if (clr)      m_ovf = 1'b0;
      m_w   = m_w + (e.push ? 1 : 0);
      lvl   = m_w - s2;
      m_full = (lvl == 16);
      s2 = s1;
      s1 = rcnt;
    end
    e.waddr = m_w[3:0];
    e.gray  = to_gray(m_w);
    e.full  = m_full;
    e.afull = (lvl >= 12);
    e.level = lvl[4:0];
    e.ovf   = m_ovf;
    q.push_back(e);
    @(posedge wclk);
    #1;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);

    // Fill: 16 consecutive writes with the reader idle, then check one idle cycle
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);

    // Overflow: write while full, clear, then clear together with a write
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);

    // Full release: one read becomes visible on the third edge, then a write is accepted
    rcnt = 1;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);

    // Almost full: 11 writes stays low, 12 writes raises it
    step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 11; i++) step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);

    // Wrap: a fast reader keeps the level low while the pointer passes 31
    step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 120; i++) begin
      if (rcnt < m_w) rcnt++;
      step(1'($urandom_range(0, 3) != 0), 1'b0, 1'b0);
    end

    // Random mix: bursty writer, slow reader, random clears, rare resets
    for (int i = 0; i < 400; i++) begin
      if (rcnt < m_w && $urandom_range(0, 2) == 0) rcnt++;
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0),
           1'($urandom_range(0, 99) == 0));
    end

    // Reset mid-stream with a write request in the same cycle
    step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);

    repeat (2) @(posedge wclk);
    #1;
    chk("queue_drain", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_wptr_full.md
Name: fifo_wptr_full

Overview:
Write-domain pointer and full-flag generator for the asynchronous FIFO. It sits directly upstream of the dual-port FIFO memory. It drives `waddr` and `wfull` into the memory and exports a Gray-coded write pointer to the read domain. It also synchronises the read-domain Gray pointer into `wclk` and derives the full flag, almost-full flag, fill level and a sticky overflow flag.

Parameters:
- ADDR_WIDTH, 4: memory address width; depth is 2**ADDR_WIDTH; must be >= 2.
- AFULL_THRESH, 12: fill level at or above which `walmost_full` asserts; range 1..2**ADDR_WIDTH.

Ports:
- wclk, input, 1: write-domain clock.
- wrst, input, 1: synchronous active-high reset.
- winc, input, 1: write request from producer.
- rptr_gray, input, ADDR_WIDTH+1: Gray read pointer from the read domain; asynchronous to `wclk`.
- wovf_clr, input, 1: clears the sticky overflow flag.
- waddr, output, ADDR_WIDTH: memory write address.
- wptr_gray, output, ADDR_WIDTH+1: registered Gray write pointer, exported to the read domain.
- wfull, output, 1: FIFO full; gates memory writes.
- walmost_full, output, 1: fill level >= AFULL_THRESH.
- wlevel, output, ADDR_WIDTH+1: conservative write-side fill count, 0..2**ADDR_WIDTH.
- woverflow, output, 1: sticky; a write was attempted while full.

Behaviour:
- Single clock `wclk`. All state updates on the rising edge. Reset is synchronous, active-high; `wrst` has priority over all other inputs.
- Reset values: internal binary pointer `wbin` = 0, `wptr_gray` = 0, both synchroniser stages = 0, `wfull` = 0, `walmost_full` = 0, `wlevel` = 0, `woverflow` = 0. Consequently `waddr` = 0.
- Accept condition: `wpush = winc && !wfull`.
- Pointer next values:
  - `wbin_next = wbin + wpush`, modulo 2**(ADDR_WIDTH+1).
  - `wgray_next = (wbin_next >> 1) ^ wbin_next`.
  - Both are registered each cycle.
- Address: `waddr = wbin[ADDR_WIDTH-1:0]`, driven combinationally from the register. The memory writes `wdata` at `waddr` on the same edge that advances the pointer; there is zero-cycle address latency.
- Synchroniser: two-flop chain `wq1 <= rptr_gray`, `wq2 <= wq1`. No logic may sit between the flops.
- Full flag (registered):
  - `wfull <= (wgray_next == {~wq2[AW:AW-1], wq2[AW-2:0]})`, where AW = ADDR_WIDTH.
  - `wfull` rises on the same edge as the push that fills the last slot.
  - A read-pointer change reaches `wfull` on the 3rd `wclk` edge after it is stable at `rptr_gray`. This is pessimistic only; it never permits overflow.
- Level (registered):
  - `wlevel <= wbin_next - gray2bin(wq2)`, computed modulo 2**(ADDR_WIDTH+1).
  - `gray2bin` is an XOR prefix from the MSB.
  - `wlevel` == 2**ADDR_WIDTH exactly when `wfull` is 1.
- Almost full (registered): `walmost_full <= (level_next >= AFULL_THRESH)`, using the same `level_next` that feeds `wlevel`.
- Overflow:
  - `winc && wfull` sets `woverflow` on the next edge.
  - A rejected write changes neither pointer nor memory.
  - `wovf_clr` clears `woverflow`; when set and clear occur in the same cycle, set wins.
- Wrap-around: `wbin` rolls over from 2**(AW+1)-1 to 0 with no special handling. The Gray code changes exactly one bit per push, including across the wrap.
- Reset mid-operation: all state returns to reset values on that edge. A `winc` in the same cycle is ignored. The read side must be reset together with the write side; cross-domain reset sequencing is the top level's responsibility.
- `winc` held high while full: no pointer motion; `woverflow` stays set. Writing resumes on the first cycle after `wfull` falls.

Test Plan:
- Reset, then 16 consecutive `winc` with `rptr_gray` = 0 -> `waddr` steps 0..15; `wptr_gray` = 0,1,3,2,6,...,0x18; `wfull` = 1 after the 16th edge; `wlevel` = 16; `woverflow` = 0.
- Fill level: from empty, push 12 -> `walmost_full` rises on the 12th push edge with `wlevel` = 12. Push 11 only -> `walmost_full` stays 0.
- Overflow: when full, assert `winc` for 3 cycles -> `wptr_gray` stays at 0x18 and `waddr` at 0; `woverflow` = 1 and remains 1. Pulse `wovf_clr` -> 0 next edge. Assert `wovf_clr` together with `winc` while full -> `woverflow` stays 1.
- Full release latency: when full, drive `rptr_gray` = 0x01 -> `wfull` deasserts exactly on the 3rd `wclk` edge and `wlevel` = 15. A `winc` on that cycle is accepted at `waddr` = 0.
- Wrap: 40 pushes with the reader model keeping level <= 4 -> `wbin` wraps past 31. Check: Gray single-bit change per push, `waddr` sequence continuous mod 16, `wfull` never asserts.
- Reset mid-stream: after 7 pushes assert `wrst` with `winc` = 1 -> next edge `waddr` = 0, `wptr_gray` = 0, all flags 0, `wlevel` = 0.
